// File: rtl/dmem_responder_if.sv
// Load/store bus between the memory stage and the data-memory responder.
// master: request side (Enable/Wr/Addr/DataIn); slave: responder side.
interface dmem_responder_if;
  logic        Enable;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Stall;
  logic        Done;
  logic        Err;

  modport master (
    output Enable,
    output Wr,
    output Addr,
    output DataIn,
    input  DataOut,
    input  Stall,
    input  Done,
    input  Err
  );

  modport slave (
    input  Enable,
    input  Wr,
    input  Addr,
    input  DataIn,
    output DataOut,
    output Stall,
    output Done,
    output Err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, Stall while
// busy, Done pulse LATENCY cycles after acceptance, Err on misalignment.
// Ports: clk, rst (sync, active-high), bus (dmem_responder_if.slave).
module dmem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [15:0]             data_q, data_d;
  logic [15:0]             dout_q, dout_d;
  logic                    stall_q, stall_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    mem_we;
  logic [15:0]             mem_q [DEPTH];

  // Upper address bits alias onto the storage array.
  logic unused_addr;
  assign unused_addr = ^bus.Addr[15:DEPTH_LOG2+1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    dout_d  = dout_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Enable) begin
          if (bus.Addr[0]) begin
            err_d = 1'b1;
          end else begin
            wr_d    = bus.Wr;
            idx_d   = bus.Addr[DEPTH_LOG2:1];
            data_d  = bus.DataIn;
            cnt_d   = CNT_INIT;
            // Stall covers the countdown only; LATENCY=1 never stalls.
            stall_d = (CNT_INIT != 4'd0);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          stall_d = (cnt_q != 4'd1);
        end else begin
          mem_we  = wr_q;
          if (!wr_q) begin
            dout_d = mem_q[idx_q];
          end
          done_d  = 1'b1;
          stall_d = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      dout_q  <= '0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (mem_we) begin
        mem_q[idx_q] <= data_q;
      end
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.Stall   = stall_q;
  assign bus.Done    = done_q;
  assign bus.Err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded random/directed bench for dmem_responder.
// Driver pushes expected responses; monitor pops on Done/Err.
module tb_dmem_responder;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();

  dmem_responder #(.LATENCY(L), .DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );

  dmem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  typedef struct {
    bit          err;
    logic [15:0] dout;
    int          acc;
  } exp_t;

  exp_t        sbq [$];
  logic [15:0] mem_m [1024];
  logic [15:0] last_rd;
  int          cyc = 0;
  int          resp_n = 0;
  int          stall_run = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every Done/Err against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_run = 0;
    end else begin
      if (if0.Stall) stall_run++;
      if (if0.Done || if0.Err) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("resp_kind", if0.Err, e.err);
          chk("dout", if0.DataOut, e.dout);
          if (e.err) begin
            chk("err_latency", cyc, e.acc);
            chk("err_nostall", stall_run, 0);
          end else begin
            chk("done_latency", cyc, e.acc + L);
            chk("stall_cycles", stall_run, L - 1);
            chk("stall_at_done", if0.Stall, 0);
            chk("err_at_done", if0.Err, 0);
          end
        end
        stall_run = 0;
        resp_n++;
      end
    end
  end

  // Issue one request; called just after a negedge with the DUT idle.
  task automatic req(input bit w, input logic [15:0] a,
                     input logic [15:0] d, input int gap,
                     input bit scr);
    exp_t e;
    int   n0;
    bit   got;
    if0.Enable = 1'b1;
    if0.Wr     = w;
    if0.Addr   = a;
    if0.DataIn = d;
    e.acc  = cyc + 1;
    e.err  = a[0];
    e.dout = last_rd;
    if (!a[0]) begin
      if (w) begin
        mem_m[a[10:1]] = d;
      end else begin
        e.dout  = mem_m[a[10:1]];
        last_rd = e.dout;
      end
    end
    sbq.push_back(e);
    n0  = resp_n;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      #1;
      if (scr && i == 0) begin
        if0.Addr   = 16'h0006;
        if0.DataIn = 16'hFFFF;
      end
      if (resp_n != n0) got = 1'b1;
    end
    if (!got) begin
      chk("resp_timeout", 0, 1);
      void'(sbq.pop_front());
    end
    if (gap > 0) begin
      if0.Enable = 1'b0;
      repeat (gap) @(negedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) mem_m[i] = '0;
    last_rd = '0;
    sbq.delete();
  endtask

  task automatic chk_reset_state();
    chk("rst_dout", if0.DataOut, 0);
    chk("rst_stall", if0.Stall, 0);
    chk("rst_done", if0.Done, 0);
    chk("rst_err", if0.Err, 0);
  endtask

  // LATENCY=1 instance: directed, sampled 1 time unit after posedge.
  task automatic l1_req(input bit w, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] x);
    if1.Enable = 1'b1;
    if1.Wr     = w;
    if1.Addr   = a;
    if1.DataIn = d;
    @(posedge clk);
    #1;
    chk("l1_stall_acc", if1.Stall, 0);
    chk("l1_done_acc", if1.Done, 0);
    @(posedge clk);
    #1;
    chk("l1_done", if1.Done, 1);
    chk("l1_stall_done", if1.Stall, 0);
    chk("l1_dout", if1.DataOut, x);
    if1.Enable = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    if0.Enable = 0; if0.Wr = 0; if0.Addr = 0; if0.DataIn = 0;
    if1.Enable = 0; if1.Wr = 0; if1.Addr = 0; if1.DataIn = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state();
    chk("rst_l1_done", if1.Done, 0);
    chk("rst_l1_dout", if1.DataOut, 0);
    #1;

    req(0, 16'h0010, 16'h0000, 1, 0);
    req(1, 16'h0020, 16'hBEEF, 0, 0);
    req(0, 16'h0020, 16'h0000, 0, 0);
    req(0, 16'h0021, 16'h0000, 1, 0);
    req(1, 16'h0004, 16'h1234, 0, 1);
    req(0, 16'h0006, 16'h0000, 0, 0);
    req(0, 16'h0004, 16'h0000, 2, 0);

    // Reset two cycles after accepting a write: write must be lost.
    if0.Enable = 1'b1;
    if0.Wr     = 1'b1;
    if0.Addr   = 16'h0008;
    if0.DataIn = 16'hAAAA;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    if0.Enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset_state();
    #1;
    req(0, 16'h0008, 16'h0000, 0, 0);

    req(1, 16'h0802, 16'h5555, 0, 0);
    req(0, 16'h0002, 16'h0000, 1, 0);

    l1_req(1, 16'h0802, 16'h5555, 16'h0000);
    l1_req(0, 16'h0002, 16'h0000, 16'h5555);
    l1_req(0, 16'h0802, 16'h0000, 16'h5555);
    @(negedge clk);
    #1;

    for (int n = 0; n < 200; n++) begin
      a = 16'($urandom_range(0, 15)) << 1;
      a = a | (16'($urandom_range(0, 31)) << 11);
      if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
      req(1'($urandom_range(0, 1)), a, 16'($urandom),
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    if0.Enable = 1'b0;
    repeat (L + 3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
